cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
- Common-data-bus transmitter for the Tomasulo core. It collects completed results (tag plus value) from NUM_SRC functional units and buffers each source in a small FIFO.
- Each cycle it grants at most one buffered result, round-robin, onto the broadcast bus (BCEN/BClabel/BCdata).
- Every reservation-station queue and the register-status table snoop that bus to clear pending tags.

Parameters:
- NUM_SRC, 4, number of functional-unit result sources (2..8).
- DEPTH, 2, entries per source FIFO (power of two, 2..4).
- LABEL_W, 4, tag width; tag 0 means "no tag / value ready".
- DATA_W, 32, result width.

Ports:
- clk  in  1  rising-edge clock.
- nRST  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  bit i: source i presents a result this cycle.
- src_label  in  NUM_SRC*LABEL_W  source i tag in bits [i*LABEL_W +: LABEL_W].
- src_data  in  NUM_SRC*DATA_W  source i value in bits [i*DATA_W +: DATA_W].
- src_ready  out  NUM_SRC  bit i: source i FIFO can accept this cycle.
- BCEN  out  1  broadcast valid, one-cycle pulse per result.
- BClabel  out  LABEL_W  broadcast tag.
- BCdata  out  DATA_W  broadcast value.
- drop_err  out  1  pulse: a result with tag 0 was presented and discarded.
- pending  out  1  at least one FIFO entry not yet broadcast.

Behaviour:
- Reset (async, nRST=0):
  - All FIFOs emptied; round-robin pointer set to 0.
  - BCEN=0, BClabel=0, BCdata=0, drop_err=0, pending=0, src_ready=all ones.
  - Reset mid-operation discards all buffered results without broadcasting them.
- Accept:
  - Source i is written on a clock edge when src_valid[i] && src_ready[i] && src_label_i != 0.
  - src_ready[i] = (count_i < DEPTH), computed from the registered count only. A full FIFO is not ready even if it pops in the same cycle.
  - src_valid while not ready: no write. The source must hold its result.
  - Tag 0 with src_valid[i] && src_ready[i]: not written. drop_err=1 on the next cycle (registered OR over all sources).
- Arbitration (combinational, from registered FIFO state):
  - Candidates are the non-empty FIFOs.
  - Search starts at index ptr and wraps modulo NUM_SRC. The first non-empty FIFO is granted and its head is popped.
  - After a grant to g, ptr <= (g+1) mod NUM_SRC. With no grant, ptr holds.
- Broadcast output (registered):
  - On a grant, the next edge sets BCEN=1 and BClabel/BCdata to the head entry. Otherwise BCEN=0 and BClabel/BCdata=0.
  - Latency: a result accepted at edge t is broadcast at edge t+1 at the earliest, i.e. the bus is valid during the cycle after acceptance.
  - A result written into an empty FIFO is not granted in the same cycle it is written (no bypass).
- Throughput: at most 1 broadcast per cycle. Sustained per-source rate is fair; no source waits more than NUM_SRC-1 grants once its FIFO is non-empty.
- Simultaneous push and pop on one FIFO in the same cycle is legal. count_i is unchanged, and ordering within a source is FIFO.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap naturally. count_i is log2(DEPTH)+1 bits.
- Tag uniqueness is the issue unit's responsibility. Duplicate in-flight tags are broadcast in grant order without checking.
- pending = OR of (count_i != 0), registered-state based (combinational from registers).

Decomposition:
- Shared header/package: LABEL_W, DATA_W, LABEL_NONE=0, and the existing queue/station tag constants, so that broadcaster and queues agree on tag encoding.
- One sub-module, cdb_src_fifo, instantiated NUM_SRC times via generate.
  - Ports: clk, nRST, push, push_label, push_data, pop, head_label, head_data, empty, full, count.
  - Arbiter, pointer and output registers stay in the top module.

Test Plan:
- Reset then idle: hold nRST=0 for 2 cycles -> BCEN=0, BClabel=0, BCdata=0, src_ready=4'b1111, pending=0. Assert nRST low mid-stream with 3 entries buffered -> outputs go to 0 immediately, and no broadcast follows release.
- Single result: src_valid=4'b0010, label=5, data=32'hDEADBEEF at edge t -> next cycle BCEN=1, BClabel=5, BCdata=32'hDEADBEEF for exactly one cycle; pending back to 0.
- Round-robin: all 4 sources push in the same cycle with labels 1,2,3,4 and ptr=0 -> broadcasts on 4 consecutive cycles with labels 1,2,3,4. Then source 0 pushes label 6 while source 2 pushes label 7 with ptr=0 -> order is 6, then 7.
- Full/backpressure: source 3 pushes labels 8,9 on back-to-back cycles while sources 0..2 are kept busy -> src_ready[3]=0 once count=2. A third push attempt (label 10) is ignored. Broadcast order for source 3 is 8, 9, then 10 only after a re-present.
- Simultaneous push/pop: source 1 with count=1 is granted while pushing a new label in the same cycle -> count stays 1, src_ready[1] stays 1, and tags leave in push order.
- Tag-0 drop: src_valid[0]=1, label=0, data=5 -> no write, drop_err=1 for one cycle, no BCEN, pending unchanged.

Source files
------------

// File: rtl/cdb_broadcaster_pkg.sv
// Shared tag encoding and bus widths for the common data bus and the queues
// and reservation stations that snoop it.
`default_nettype none

package cdb_broadcaster_pkg;

  localparam int CDB_LABEL_W = 4;
  localparam int CDB_DATA_W  = 32;

  // Tag 0 marks an operand that is already valid.
  localparam logic [CDB_LABEL_W-1:0] LABEL_NONE = '0;

  // Reservation-station tag assignment used by the issue unit.
  localparam logic [CDB_LABEL_W-1:0] TAG_ALU_BASE = 4'd1;
  localparam logic [CDB_LABEL_W-1:0] TAG_MUL_BASE = 4'd5;
  localparam logic [CDB_LABEL_W-1:0] TAG_LD_BASE  = 4'd9;
  localparam logic [CDB_LABEL_W-1:0] TAG_ST_BASE  = 4'd13;

  function automatic logic is_label_none(input logic [CDB_LABEL_W-1:0] label);
    return label == LABEL_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: power-of-two depth, naturally wrapping pointers.
`default_nettype none

module cdb_src_fifo #(
  parameter int DEPTH   = 2,
  parameter int LABEL_W = 4,
  parameter int DATA_W  = 32
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     push,
  input  logic [LABEL_W-1:0]       push_label,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [LABEL_W-1:0]       head_label,
  output logic [DATA_W-1:0]        head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [LABEL_W-1:0] mem_label [DEPTH];
  logic [DATA_W-1:0]  mem_data  [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_label = mem_label[rd_ptr];
  assign head_data  = mem_data[rd_ptr];

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_label[wr_ptr] <= push_label;
      mem_data[wr_ptr]  <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_broadcaster.sv
// Common-data-bus transmitter: buffers per-source results and broadcasts one
// per cycle with a round-robin grant.
`default_nettype none

module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2,
  parameter int LABEL_W = CDB_LABEL_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                         clk,
  input  logic                         nRST,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*LABEL_W-1:0]   src_label,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         BCEN,
  output logic [LABEL_W-1:0]           BClabel,
  output logic [DATA_W-1:0]            BCdata,
  output logic                         drop_err,
  output logic                         pending
);

  localparam int PW = $clog2(NUM_SRC);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] drop_hit;
  logic [NUM_SRC-1:0] nonzero;
  logic [LABEL_W-1:0] head_label [NUM_SRC];
  logic [DATA_W-1:0]  head_data  [NUM_SRC];
  logic [CW-1:0]      count      [NUM_SRC];

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] grant_idx;
  logic          grant_vld;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [LABEL_W-1:0] lbl;
    logic               lbl_none;

    assign lbl          = src_label[gi*LABEL_W +: LABEL_W];
    assign lbl_none     = (lbl == LABEL_W'(LABEL_NONE));
    assign src_ready[gi] = ~full[gi];
    assign push[gi]     = src_valid[gi] & ~full[gi] & ~lbl_none;
    assign drop_hit[gi] = src_valid[gi] & ~full[gi] & lbl_none;
    assign nonzero[gi]  = |count[gi];

    cdb_src_fifo #(
      .DEPTH   (DEPTH),
      .LABEL_W (LABEL_W),
      .DATA_W  (DATA_W)
    ) u_fifo (
      .clk        (clk),
      .nRST       (nRST),
      .push       (push[gi]),
      .push_label (lbl),
      .push_data  (src_data[gi*DATA_W +: DATA_W]),
      .pop        (pop[gi]),
      .head_label (head_label[gi]),
      .head_data  (head_data[gi]),
      .empty      (empty[gi]),
      .full       (full[gi]),
      .count      (count[gi])
    );
  end

  assign pending = |nonzero;

  // First non-empty FIFO at or after ptr, wrapping modulo NUM_SRC.
  always_comb begin
    logic [PW-1:0] cand;
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    pop       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_SRC);
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) pop[grant_idx] = 1'b1;
    ptr_next = (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ptr      <= '0;
      BCEN     <= 1'b0;
      BClabel  <= '0;
      BCdata   <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= |drop_hit;
      BCEN     <= grant_vld;
      if (grant_vld) begin
        ptr     <= ptr_next;
        BClabel <= head_label[grant_idx];
        BCdata  <= head_data[grant_idx];
      end else begin
        BClabel <= '0;
        BCdata  <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: expected broadcasts are queued as
// stimulus is driven and compared whenever BCEN is seen.
`default_nettype none

module tb_cdb_broadcaster;

  logic         clk = 1'b0;
  logic         nRST;
  logic [3:0]   src_valid;
  logic [15:0]  src_label;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic         BCEN;
  logic [3:0]   BClabel;
  logic [31:0]  BCdata;
  logic         drop_err;
  logic         pending;

  int checks   = 0;
  int failures = 0;
  logic [35:0] sb [$];

  always #5 clk = ~clk;

  cdb_broadcaster dut (
    .clk       (clk),
    .nRST      (nRST),
    .src_valid (src_valid),
    .src_label (src_label),
    .src_data  (src_data),
    .src_ready (src_ready),
    .BCEN      (BCEN),
    .BClabel   (BClabel),
    .BCdata    (BCdata),
    .drop_err  (drop_err),
    .pending   (pending)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int l);
    return 32'hC0DE_0000 + 32'(l);
  endfunction

  task automatic present(input int s, input int l, input logic [31:0] d);
    src_valid[s]           = 1'b1;
    src_label[s*4 +: 4]    = 4'(l);
    src_data[s*32 +: 32]   = d;
  endtask

  task automatic expect_bc(input int l, input logic [31:0] d);
    sb.push_back({4'(l), d});
  endtask

  task automatic tick();
    @(negedge clk);
    src_valid = '0;
    src_label = '0;
    src_data  = '0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check_eq(tag, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    logic [35:0] e;
    if (nRST && BCEN) begin
      if (sb.size() == 0) begin
        check_eq("spurious_bcen", {60'd0, BClabel}, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("bc_label", 64'(BClabel), 64'(e[35:32]));
        check_eq("bc_data",  64'(BCdata),  64'(e[31:0]));
      end
    end
  end

  initial begin
    nRST = 1'b0;
    src_valid = '0;
    src_label = '0;
    src_data  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_bcen",    64'(BCEN),      64'd0);
    check_eq("rst_label",   64'(BClabel),   64'd0);
    check_eq("rst_data",    64'(BCdata),    64'd0);
    check_eq("rst_ready",   64'(src_ready), 64'hF);
    check_eq("rst_pending", 64'(pending),   64'd0);
    check_eq("rst_drop",    64'(drop_err),  64'd0);
    nRST = 1'b1;
    @(negedge clk);

    // Single result from source 1
    present(1, 5, 32'hDEADBEEF);
    expect_bc(5, 32'hDEADBEEF);
    tick();
    check_eq("single_pending_hi", 64'(pending), 64'd1);
    tick();
    check_eq("single_bcen", 64'(BCEN), 64'd1);
    check_eq("single_pending_lo", 64'(pending), 64'd0);
    tick();
    check_eq("single_one_cycle", 64'(BCEN), 64'd0);

    // Source 3 result moves the pointer back to 0
    present(3, 11, dat(11));
    expect_bc(11, dat(11));
    tick();
    drain("drain_ptr_align");

    // Round-robin from ptr=0
    for (int s = 0; s < 4; s++) begin
      present(s, s + 1, dat(s + 1));
      expect_bc(s + 1, dat(s + 1));
    end
    tick();
    check_eq("rr_ready", 64'(src_ready), 64'hF);
    drain("drain_rr");

    present(0, 6, dat(6));
    present(2, 7, dat(7));
    expect_bc(6, dat(6));
    expect_bc(7, dat(7));
    tick();
    drain("drain_rr2");

    // Backpressure on source 3 (ptr=3)
    foreach (sb[i]) sb.delete(i);
    expect_bc(20, dat(20)); expect_bc(21, dat(21)); expect_bc(22, dat(22));
    expect_bc(8, dat(8));   expect_bc(23, dat(23)); expect_bc(24, dat(24));
    expect_bc(25, dat(25)); expect_bc(9, dat(9));   expect_bc(10, dat(10));
    present(0, 20, dat(20)); present(1, 21, dat(21)); present(2, 22, dat(22));
    tick();
    present(0, 23, dat(23)); present(1, 24, dat(24)); present(2, 25, dat(25));
    present(3, 8, dat(8));
    tick();
    present(3, 9, dat(9));
    tick();
    check_eq("bp_ready3_full", 64'(src_ready[3]), 64'd0);
    present(3, 10, dat(10));
    tick();
    check_eq("bp_ready3_still_full", 64'(src_ready[3]), 64'd0);
    tick();
    check_eq("bp_ready3_free", 64'(src_ready[3]), 64'd1);
    repeat (5) tick();
    present(3, 10, dat(10));
    tick();
    drain("drain_bp");

    // Simultaneous push and pop on source 1 (ptr=0)
    present(1, 30, dat(30));
    expect_bc(30, dat(30));
    expect_bc(31, dat(31));
    tick();
    check_eq("pp_ready_before", 64'(src_ready[1]), 64'd1);
    present(1, 31, dat(31));
    tick();
    check_eq("pp_ready_after", 64'(src_ready[1]), 64'd1);
    check_eq("pp_pending",     64'(pending),      64'd1);
    drain("drain_pp");
    check_eq("pp_pending_done", 64'(pending), 64'd0);

    // Tag-0 drop
    present(0, 0, 32'd5);
    tick();
    check_eq("drop_err_hi",  64'(drop_err), 64'd1);
    check_eq("drop_pending", 64'(pending),  64'd0);
    check_eq("drop_no_bcen", 64'(BCEN),     64'd0);
    tick();
    check_eq("drop_err_lo", 64'(drop_err), 64'd0);

    // Reset mid-stream with entries buffered (ptr=2 -> source 2 first)
    present(0, 40, dat(40)); present(1, 41, dat(41)); present(2, 42, dat(42));
    expect_bc(42, dat(42));
    tick();
    tick();
    #1 nRST = 1'b0;
    #1;
    check_eq("mid_rst_bcen",    64'(BCEN),      64'd0);
    check_eq("mid_rst_label",   64'(BClabel),   64'd0);
    check_eq("mid_rst_data",    64'(BCdata),    64'd0);
    check_eq("mid_rst_pending", 64'(pending),   64'd0);
    check_eq("mid_rst_ready",   64'(src_ready), 64'hF);
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    repeat (6) tick();
    check_eq("mid_rst_no_bc", 64'(sb.size()), 64'd0);
    check_eq("mid_rst_idle_pending", 64'(pending), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
